// File: rtl/inst_prefetch.sv
// ---------------------------------------------------------------------------
// inst_prefetch
//
// Instruction prefetch unit. Issues sequential addresses to a synchronous
// instruction ROM, queues the returned words together with their addresses
// and presents the queue head to the decoder with a valid/ready handshake.
// Redirects (taken branches/jumps) flush the queue and refetch from an
// absolute target. Start restarts fetch from address 0, and Halt stops new
// fetches while letting queued and in-flight words drain.
//
// Parameters
//   DEPTH  queue entries (power of 2, >= 2)
//   AW     instruction address width
//   IW     instruction width
//
// Ports
//   Clk             clock, all state updates on posedge
//   Reset           synchronous active-low reset
//   Start           one-cycle pulse, restart fetch at address 0
//   Halt            stop issuing new fetches
//   Redirect        flush and refetch at RedirectTarget
//   RedirectTarget  absolute refetch address
//   RomAddr         registered ROM address
//   RomData         ROM word for the previous cycle's RomAddr
//   InstValid       queue head valid
//   Instruction     queue head word
//   InstPC          address of the queue head word
//   InstReady       decoder consumes the head when InstValid && InstReady
//   Occupancy       number of queued entries
// ---------------------------------------------------------------------------
module inst_prefetch #(
    parameter int DEPTH = 4,
    parameter int AW    = 10,
    parameter int IW    = 9
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic                     Halt,
    input  logic                     Redirect,
    input  logic [AW-1:0]            RedirectTarget,
    output logic [AW-1:0]            RomAddr,
    input  logic [IW-1:0]            RomData,
    output logic                     InstValid,
    output logic [IW-1:0]            Instruction,
    output logic [AW-1:0]            InstPC,
    input  logic                     InstReady,
    output logic [$clog2(DEPTH):0]   Occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_LIMIT = DEPTH[CW:0];
    localparam logic [PW-1:0] PTR_ONE     = PW'(1);
    localparam logic [AW-1:0] ADDR_ONE    = AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALTED
    } state_t;

    state_t          state;
    logic [AW-1:0]   fetch_pc;

    // issue_valid: RomAddr holds a live request this cycle.
    // resp_valid:  RomData holds the answer to last cycle's request.
    logic            issue_valid;
    logic            resp_valid;
    logic [AW-1:0]   resp_addr;

    logic [IW-1:0]   q_data [DEPTH];
    logic [AW-1:0]   q_pc   [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    logic            flush;
    logic            push;
    logic            pop;
    logic            room;
    logic [CW-1:0]   count_next;

    // Redirect only flushes while actively fetching; Start always flushes.
    // The issue budget counts next cycle's queue plus the request currently
    // on RomAddr, whose word lands one cycle later, so a push can never
    // find the queue full.
    always_comb begin
        flush      = Start || (Redirect && (state == FETCH));
        push       = resp_valid && !flush;
        pop        = (count != '0) && InstReady;
        count_next = count + CW'(push) - CW'(pop);
        room       = ({1'b0, count_next} + (CW+1)'(issue_valid)) < DEPTH_LIMIT;
    end

    assign InstValid   = (count != '0);
    assign Instruction = InstValid ? q_data[head] : '0;
    assign InstPC      = InstValid ? q_pc[head]   : '0;
    assign Occupancy   = count;

    // Fetch control, response pipeline and queue pointers. Reset overrides
    // everything else sampled in the same cycle.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state       <= IDLE;
            fetch_pc    <= '0;
            RomAddr     <= '0;
            issue_valid <= 1'b0;
            resp_valid  <= 1'b0;
            resp_addr   <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else begin
            resp_valid <= issue_valid && !flush;
            resp_addr  <= RomAddr;

            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    tail <= tail + PTR_ONE;
                end
                if (pop) begin
                    head <= head + PTR_ONE;
                end
                count <= count_next;
            end

            if (Start) begin
                state       <= FETCH;
                RomAddr     <= '0;
                fetch_pc    <= ADDR_ONE;
                issue_valid <= 1'b1;
            end else begin
                case (state)
                    FETCH: begin
                        // Halt beats the refetch of a simultaneous redirect;
                        // the flush above still happens.
                        if (Redirect && !Halt) begin
                            RomAddr     <= RedirectTarget;
                            fetch_pc    <= RedirectTarget + ADDR_ONE;
                            issue_valid <= 1'b1;
                        end else if (Halt) begin
                            state       <= HALTED;
                            issue_valid <= 1'b0;
                        end else if (room) begin
                            RomAddr     <= fetch_pc;
                            fetch_pc    <= fetch_pc + ADDR_ONE;
                            issue_valid <= 1'b1;
                        end else begin
                            issue_valid <= 1'b0;
                        end
                    end
                    default: begin
                        issue_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Queue storage needs no reset; entries are only visible below count.
    always_ff @(posedge Clk) begin
        if (Reset && push) begin
            q_data[tail] <= RomData;
            q_pc[tail]   <= resp_addr;
        end
    end

endmodule
